// File: rtl/trena_uc_multi.sv
// Tape-measure control unit: one ultrasonic measurement, then N_CHAR serial characters.
// Adds a measurement timeout and an optional periodic (continuous) mode.
module trena_uc_multi #(
  parameter int N_CHAR      = 4,
  parameter int TIMEOUT_CYC = 2500000,
  parameter int PERIODO_CYC = 5000000,
  localparam int CW = (N_CHAR > 1) ? $clog2(N_CHAR) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          mensurar,
  input  logic          continuo,
  input  logic          fim_medida,
  input  logic          fim_digito,
  output logic          zera,
  output logic          comeca_medida,
  output logic          partida,
  output logic [CW-1:0] char_idx,
  output logic          pronto,
  output logic          timeout,
  output logic [3:0]    db_estado
);

  localparam int MAXC = (TIMEOUT_CYC > PERIODO_CYC) ?
                        TIMEOUT_CYC : PERIODO_CYC;
  localparam int TW = $clog2(MAXC + 1);

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] PE_LAST = TW'(PERIODO_CYC - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(N_CHAR - 1);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    AGUARDA   = 4'd2,
    TRANSMITE = 4'd3,
    ESPERA    = 4'd4,
    PROXIMO   = 4'd5,
    FINAL     = 4'd6,
    ERRO      = 4'd7,
    INTERVALO = 4'd8
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_char;
  logic          w_to_hit;
  logic          w_pe_hit;
  logic          w_ch_last;

  assign w_to_hit  = (r_timer == TO_LAST);
  assign w_pe_hit  = (r_timer == PE_LAST);
  assign w_ch_last = (r_char == CH_LAST);
  assign char_idx  = r_char;

  always_ff @(posedge clock) begin
    if (reset) r_state <= INICIAL;
    else       r_state <= w_next;
  end

  // Any state change restarts the timer, so each timed state counts from 0.
  always_ff @(posedge clock) begin
    if (reset)
      r_timer <= '0;
    else if (w_next != r_state)
      r_timer <= '0;
    else if (r_state == AGUARDA || r_state == INTERVALO)
      r_timer <= r_timer + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_char <= '0;
    else if (r_state == PREPARA)
      r_char <= '0;
    else if (r_state == PROXIMO && !w_ch_last)
      r_char <= r_char + 1'b1;
  end

  always_comb begin
    w_next        = r_state;
    zera          = 1'b0;
    comeca_medida = 1'b0;
    partida       = 1'b0;
    pronto        = 1'b0;
    timeout       = 1'b0;
    db_estado     = r_state;
    unique case (r_state)
      INICIAL: begin
        zera = 1'b1;
        if (mensurar) w_next = PREPARA;
      end
      PREPARA: begin
        zera   = 1'b1;
        w_next = AGUARDA;
      end
      AGUARDA: begin
        comeca_medida = 1'b1;
        if (fim_medida)    w_next = TRANSMITE;
        else if (w_to_hit) w_next = ERRO;
      end
      TRANSMITE: begin
        partida = 1'b1;
        w_next  = ESPERA;
      end
      ESPERA: begin
        if (fim_digito) w_next = PROXIMO;
      end
      PROXIMO: begin
        w_next = w_ch_last ? FINAL : TRANSMITE;
      end
      FINAL: begin
        pronto = 1'b1;
        w_next = continuo ? INTERVALO : INICIAL;
      end
      ERRO: begin
        timeout = 1'b1;
        w_next  = continuo ? INTERVALO : INICIAL;
      end
      INTERVALO: begin
        if (!continuo)     w_next = INICIAL;
        else if (w_pe_hit) w_next = PREPARA;
      end
      default: begin
        db_estado = 4'hF;
        w_next    = INICIAL;
      end
    endcase
  end

endmodule

// File: tb/tb_trena_uc_multi.sv
// Directed bench for trena_uc_multi: a 4-char unit (timeout 20, period 6)
// and a 1-char unit (timeout 8) exercised cycle by cycle.
module tb_trena_uc_multi;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic m4 = 0, c4 = 0, fm4 = 0, fd4 = 0;
  logic z4, cm4, p4, pr4, to4;
  logic [1:0] ci4;
  logic [3:0] db4;

  logic m1 = 0, c1 = 0, fm1 = 0, fd1 = 0;
  logic z1, cm1, p1, pr1, to1;
  logic [0:0] ci1;
  logic [3:0] db1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  trena_uc_multi #(
    .N_CHAR(4), .TIMEOUT_CYC(20), .PERIODO_CYC(6)
  ) u_dut4 (
    .clock(clk), .reset(rst),
    .mensurar(m4), .continuo(c4),
    .fim_medida(fm4), .fim_digito(fd4),
    .zera(z4), .comeca_medida(cm4),
    .partida(p4), .char_idx(ci4),
    .pronto(pr4), .timeout(to4),
    .db_estado(db4)
  );

  trena_uc_multi #(
    .N_CHAR(1), .TIMEOUT_CYC(8), .PERIODO_CYC(6)
  ) u_dut1 (
    .clock(clk), .reset(rst),
    .mensurar(m1), .continuo(c1),
    .fim_medida(fm1), .fim_digito(fd1),
    .zera(z1), .comeca_medida(cm1),
    .partida(p1), .char_idx(ci1),
    .pronto(pr1), .timeout(to1),
    .db_estado(db1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entered at a negedge with u_dut4 in PREPARA; leaves it in FINAL.
  task automatic tx4(input int med_wait);
    step();
    chk("ag_cm", cm4, 1);
    chk("ag_db", db4, 2);
    chk("ag_zera", z4, 0);
    repeat (med_wait) begin
      step();
      chk("ag_wait_db", db4, 2);
    end
    fm4 = 1;
    step();
    fm4 = 0;
    for (int k = 0; k < 4; k++) begin
      chk("tx_part", p4, 1);
      chk("tx_idx", ci4, k);
      chk("tx_db", db4, 3);
      step();
      chk("es_part", p4, 0);
      chk("es_db", db4, 4);
      repeat (3) step();
      chk("es_idx", ci4, k);
      fd4 = 1;
      step();
      fd4 = 0;
      chk("px_db", db4, 5);
      step();
    end
    chk("fin_pronto", pr4, 1);
    chk("fin_db", db4, 6);
    chk("fin_idx", ci4, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) step();
    chk("rst_db", db4, 0);
    chk("rst_zera", z4, 1);
    chk("rst_cm", cm4, 0);
    chk("rst_part", p4, 0);
    chk("rst_pronto", pr4, 0);
    chk("rst_to", to4, 0);
    chk("rst_idx", ci4, 0);
    chk("rst_db1", db1, 0);
    rst = 0;
    step();
    chk("idle_db", db4, 0);

    // T1: single measurement, 4 characters
    m4 = 1;
    step();
    m4 = 0;
    chk("t1_prep_db", db4, 1);
    chk("t1_prep_zera", z4, 1);
    tx4(8);
    step();
    chk("t1_end_db", db4, 0);
    chk("t1_end_pronto", pr4, 0);
    chk("t1_end_zera", z4, 1);

    // T4: continuous mode, 6-cycle interval, then abort
    c4 = 1;
    m4 = 1;
    step();
    m4 = 0;
    chk("t4_prep_db", db4, 1);
    tx4(2);
    step();
    for (int i = 0; i < 6; i++) begin
      chk("t4_int_db", db4, 8);
      step();
    end
    chk("t4_reprep_db", db4, 1);
    chk("t4_reprep_zera", z4, 1);
    tx4(0);
    step();
    chk("t4_int2_db", db4, 8);
    step();
    chk("t4_int2b_db", db4, 8);
    c4 = 0;
    step();
    chk("t4_abort_db", db4, 0);

    // T5: reset in ESPERA with char_idx 2
    m4 = 1;
    step();
    m4 = 0;
    step();
    fm4 = 1;
    step();
    fm4 = 0;
    repeat (2) begin
      step();
      fd4 = 1;
      step();
      fd4 = 0;
      step();
    end
    step();
    chk("t5_es_db", db4, 4);
    chk("t5_es_idx", ci4, 2);
    rst = 1;
    step();
    rst = 0;
    chk("t5_rst_db", db4, 0);
    chk("t5_rst_idx", ci4, 0);
    chk("t5_rst_zera", z4, 1);
    fd4 = 1;
    step();
    fd4 = 0;
    chk("t5_late_db", db4, 0);
    chk("t5_late_part", p4, 0);
    step();
    chk("t5_late2_db", db4, 0);

    // T2: timeout after exactly 8 AGUARDA cycles
    m1 = 1;
    step();
    m1 = 0;
    chk("t2_prep_db", db1, 1);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("t2_ag_cm", cm1, 1);
      chk("t2_ag_part", p1, 0);
      step();
    end
    chk("t2_erro_to", to1, 1);
    chk("t2_erro_db", db1, 7);
    chk("t2_erro_cm", cm1, 0);
    chk("t2_erro_part", p1, 0);
    step();
    chk("t2_end_db", db1, 0);
    chk("t2_end_to", to1, 0);

    // T3 + T6: fim_medida on the last AGUARDA cycle, N_CHAR=1
    m1 = 1;
    step();
    m1 = 0;
    step();
    repeat (7) step();
    chk("t3_ag8_db", db1, 2);
    chk("t3_ag8_cm", cm1, 1);
    fm1 = 1;
    step();
    fm1 = 0;
    chk("t3_tx_db", db1, 3);
    chk("t3_tx_part", p1, 1);
    chk("t3_tx_to", to1, 0);
    chk("t6_tx_idx", ci1, 0);
    m1 = 1;
    step();
    chk("t6_es_part", p1, 0);
    chk("t6_es_db", db1, 4);
    step();
    chk("t6_es2_db", db1, 4);
    fd1 = 1;
    step();
    fd1 = 0;
    chk("t6_px_db", db1, 5);
    chk("t6_px_pronto", pr1, 0);
    step();
    chk("t6_fin_pronto", pr1, 1);
    chk("t6_fin_db", db1, 6);
    chk("t6_fin_part", p1, 0);
    step();
    chk("t6_ini_db", db1, 0);
    chk("t6_ini_pronto", pr1, 0);
    step();
    chk("t6_restart_db", db1, 1);
    m1 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
